// File: rtl/hit_resolver.sv
// Target-grid hit filter: owns the alive mask, retires the projectile through a
// level kill handshake, keeps a saturating score and flags wave completion.
module hit_resolver #(
    parameter int GRID_ROWS     = 3,
    parameter int GRID_COLS     = 8,
    parameter int SCORE_PER_HIT = 10,
    parameter int SCORE_W       = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_collision_detected,
    input  logic [2:0]                     i_hit_row,
    input  logic [3:0]                     i_hit_col,
    input  logic                           i_obj1_active,
    input  logic                           i_wave_start,
    input  logic                           i_score_clear,
    input  logic [2:0]                     i_query_row,
    input  logic [3:0]                     i_query_col,
    output logic                           o_query_alive,
    output logic [GRID_ROWS*GRID_COLS-1:0] o_alive_mask,
    output logic [4:0]                     o_alive_count,
    output logic                           o_hit_valid,
    output logic [2:0]                     o_hit_row,
    output logic [3:0]                     o_hit_col,
    output logic                           o_obj1_kill,
    output logic [SCORE_W-1:0]             o_score,
    output logic                           o_wave_cleared
);
    localparam int CELLS = GRID_ROWS * GRID_COLS;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    typedef enum logic [1:0] {ARMED, RELEASE, CLEARED} state_t;

    state_t               r_state, w_state_nxt;
    logic [CELLS-1:0]     r_mask;
    logic [4:0]           r_count;
    logic [SCORE_W-1:0]   r_score;
    logic                 r_hit_valid;
    logic [2:0]           r_hit_row;
    logic [3:0]           r_hit_col;
    logic                 r_kill, w_kill_nxt;

    logic                 w_hit_in, w_hit_alive, w_accept;
    logic [IDX_W-1:0]     w_hit_idx;
    logic                 w_q_in;
    logic [IDX_W-1:0]     w_q_idx;
    logic [SCORE_W:0]     w_score_sum;
    logic [SCORE_W-1:0]   w_score_inc;

    assign w_hit_in  = (int'(i_hit_row) < GRID_ROWS) && (int'(i_hit_col) < GRID_COLS);
    assign w_hit_idx = IDX_W'(int'(i_hit_row) * GRID_COLS + int'(i_hit_col));
    assign w_q_in    = (int'(i_query_row) < GRID_ROWS) && (int'(i_query_col) < GRID_COLS);
    assign w_q_idx   = IDX_W'(int'(i_query_row) * GRID_COLS + int'(i_query_col));

    // Range is checked before indexing so out-of-grid coordinates never alias a live cell.
    always_comb begin
        w_hit_alive = 1'b0;
        if (w_hit_in)
            w_hit_alive = r_mask[w_hit_idx];
        o_query_alive = 1'b0;
        if (w_q_in)
            o_query_alive = r_mask[w_q_idx];
    end

    assign w_accept = (r_state == ARMED) && i_collision_detected && i_obj1_active
                      && w_hit_alive && !i_wave_start;

    assign w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(SCORE_PER_HIT);
    assign w_score_inc = w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        if (i_wave_start) begin
            w_state_nxt = ARMED;
            w_kill_nxt  = 1'b0;
        end else begin
            case (r_state)
                ARMED: begin
                    if (w_accept) begin
                        w_kill_nxt  = 1'b1;
                        w_state_nxt = (r_count == 5'd1) ? CLEARED : RELEASE;
                    end
                end
                RELEASE: begin
                    if (!i_obj1_active) begin
                        w_state_nxt = ARMED;
                        w_kill_nxt  = 1'b0;
                    end
                end
                CLEARED: begin
                    if (!i_obj1_active)
                        w_kill_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = ARMED;
                    w_kill_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ARMED;
            r_kill      <= 1'b0;
            r_mask      <= {CELLS{1'b1}};
            r_count     <= 5'(CELLS);
            r_score     <= '0;
            r_hit_valid <= 1'b0;
            r_hit_row   <= '0;
            r_hit_col   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_kill      <= w_kill_nxt;
            r_hit_valid <= w_accept;
            if (i_wave_start) begin
                r_mask  <= {CELLS{1'b1}};
                r_count <= 5'(CELLS);
            end else if (w_accept) begin
                r_mask[w_hit_idx] <= 1'b0;
                r_count           <= r_count - 5'd1;
                r_hit_row         <= i_hit_row;
                r_hit_col         <= i_hit_col;
            end
            // A clear coincident with a hit leaves exactly one hit's worth of score.
            if (i_score_clear)
                r_score <= w_accept ? SCORE_W'(SCORE_PER_HIT) : '0;
            else if (w_accept)
                r_score <= w_score_inc;
        end
    end

    assign o_alive_mask   = r_mask;
    assign o_alive_count  = r_count;
    assign o_hit_valid    = r_hit_valid;
    assign o_hit_row      = r_hit_row;
    assign o_hit_col      = r_hit_col;
    assign o_obj1_kill    = r_kill;
    assign o_score        = r_score;
    assign o_wave_cleared = (r_state == CLEARED);
endmodule
